// File: rtl/multicycle_control_pkg.sv
// multicycle_control_pkg: state encodings, opcodes and select codes shared by the multicycle controller
package multicycle_control_pkg;
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_JREG   = 4'd12
  } state_e;
  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;
  localparam logic [1:0] ALU_RTYPE = 2'b00;
  localparam logic [1:0] ALU_ADD   = 2'b01;
  localparam logic [1:0] ALU_SUB   = 2'b11;
  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;
  localparam logic [1:0] PCS_REGA   = 2'b11;
  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;
endpackage

// File: rtl/multicycle_control.sv
// multicycle_control: Moore FSM sequencing a multicycle MIPS datapath
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter logic ADDI_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       jr,
  output logic [1:0] alusignal,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       pcwrite,
  output logic       pcwritecond,
  output logic       iord,
  output logic       memread,
  output logic       memwrite,
  output logic       irwrite,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       regdst,
  output logic [1:0] pcsource,
  output logic       illegal,
  output logic [3:0] state
);
  state_e state_q, state_d;
  logic   dec_ok;
  logic [1:0] aop;
  logic pcw, pcwc, mrd, mwr, irw, rw;
  always_ff @(posedge clk)
    state_q <= reset ? S_FETCH : state_d;
  assign dec_ok = opcode == OP_RTYPE || opcode == OP_LW || opcode == OP_SW ||
                  opcode == OP_BEQ || opcode == OP_J || (ADDI_EN && opcode == OP_ADDI);
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = opcode == OP_RTYPE                     ? S_EXEC   :
                          (opcode == OP_LW || opcode == OP_SW)   ? S_MEMADR :
                          opcode == OP_BEQ                       ? S_BRANCH :
                          opcode == OP_J                         ? S_JUMP   :
                          (ADDI_EN && opcode == OP_ADDI)         ? S_ADDIEX : S_FETCH;
      S_MEMADR: state_d = opcode == OP_LW ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = S_MEMWB;
      S_EXEC:   state_d = jr ? S_JREG : S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH;
    endcase
  end
  // Output decoder reads only the state register; enables are gated by reset below
  always_comb begin
    aop = ALU_RTYPE; alusrca = 1'b0; alusrcb = SRCB_REG; pcsource = PCS_ALU;
    pcw = 1'b0; pcwc = 1'b0; iord = 1'b0; mrd = 1'b0; mwr = 1'b0;
    irw = 1'b0; memtoreg = 1'b0; rw = 1'b0; regdst = 1'b0;
    case (state_q)
      S_FETCH:  begin mrd = 1'b1; irw = 1'b1; alusrcb = SRCB_FOUR; aop = ALU_ADD; pcw = 1'b1; end
      S_DECODE: begin alusrcb = SRCB_IMMSH; aop = ALU_ADD; end
      S_MEMADR: begin alusrca = 1'b1; alusrcb = SRCB_IMM; aop = ALU_ADD; end
      S_MEMRD:  begin mrd = 1'b1; iord = 1'b1; end
      S_MEMWB:  begin rw = 1'b1; memtoreg = 1'b1; end
      S_MEMWR:  begin mwr = 1'b1; iord = 1'b1; end
      S_EXEC:   alusrca = 1'b1;
      S_ALUWB:  begin rw = 1'b1; regdst = 1'b1; end
      S_BRANCH: begin alusrca = 1'b1; aop = ALU_SUB; pcwc = 1'b1; pcsource = PCS_ALUOUT; end
      S_JUMP:   begin pcw = 1'b1; pcsource = PCS_JUMP; end
      S_ADDIEX: begin alusrca = 1'b1; alusrcb = SRCB_IMM; aop = ALU_ADD; end
      S_ADDIWB: rw = 1'b1;
      S_JREG:   begin pcw = 1'b1; pcsource = PCS_REGA; end
      default:  ;
    endcase
  end
  assign alusignal   = reset ? ALU_RTYPE : aop;
  assign pcwrite     = pcw & ~reset;
  assign pcwritecond = pcwc & ~reset;
  assign memread     = mrd & ~reset;
  assign memwrite    = mwr & ~reset;
  assign irwrite     = irw & ~reset;
  assign regwrite    = rw & ~reset;
  assign illegal     = state_q == S_DECODE && !dec_ok && !reset;
  assign state       = state_q;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: scoreboard bench walking every instruction class through the controller
module tb_multicycle_control;
  typedef struct packed {
    logic [3:0] st;
    logic [1:0] aop;
    logic       asa;
    logic [1:0] asb;
    logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rw, rdst;
    logic [1:0] pcs;
    logic       ill;
  } ctl_t;
  logic clk = 1'b0, reset = 1'b1, reset0 = 1'b1, jr = 1'b0;
  logic [5:0] opcode = 6'd0;
  ctl_t obs1, obs0, sb[$];
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  logic [1:0] aop1, asb1, pcs1, aop0, asb0, pcs0;
  logic [3:0] st1, st0;
  logic asa1, pcw1, pcwc1, iord1, mrd1, mwr1, irw1, m2r1, rw1, rdst1, ill1;
  logic asa0, pcw0, pcwc0, iord0, mrd0, mwr0, irw0, m2r0, rw0, rdst0, ill0;
  multicycle_control #(.ADDI_EN(1'b1)) dut1 (
    .clk(clk), .reset(reset), .opcode(opcode), .jr(jr),
    .alusignal(aop1), .alusrca(asa1), .alusrcb(asb1), .pcwrite(pcw1), .pcwritecond(pcwc1),
    .iord(iord1), .memread(mrd1), .memwrite(mwr1), .irwrite(irw1), .memtoreg(m2r1),
    .regwrite(rw1), .regdst(rdst1), .pcsource(pcs1), .illegal(ill1), .state(st1));
  multicycle_control #(.ADDI_EN(1'b0)) dut0 (
    .clk(clk), .reset(reset0), .opcode(opcode), .jr(jr),
    .alusignal(aop0), .alusrca(asa0), .alusrcb(asb0), .pcwrite(pcw0), .pcwritecond(pcwc0),
    .iord(iord0), .memread(mrd0), .memwrite(mwr0), .irwrite(irw0), .memtoreg(m2r0),
    .regwrite(rw0), .regdst(rdst0), .pcsource(pcs0), .illegal(ill0), .state(st0));
  assign obs1 = {st1, aop1, asa1, asb1, pcw1, pcwc1, iord1, mrd1, mwr1, irw1, m2r1, rw1, rdst1, pcs1, ill1};
  assign obs0 = {st0, aop0, asa0, asb0, pcw0, pcwc0, iord0, mrd0, mwr0, irw0, m2r0, rw0, rdst0, pcs0, ill0};
  function automatic ctl_t exp_ctl(logic [3:0] st, logic bad, logic rst);
    ctl_t c;
    c = '0;
    c.st = st;
    case (st)
      4'd0:  begin c.aop = 2'b01; c.asb = 2'b01; c.pcw = 1; c.mrd = 1; c.irw = 1; end
      4'd1:  begin c.aop = 2'b01; c.asb = 2'b11; c.ill = bad; end
      4'd2:  begin c.asa = 1; c.asb = 2'b10; c.aop = 2'b01; end
      4'd3:  begin c.mrd = 1; c.iord = 1; end
      4'd4:  begin c.rw = 1; c.m2r = 1; end
      4'd5:  begin c.mwr = 1; c.iord = 1; end
      4'd6:  c.asa = 1;
      4'd7:  begin c.rw = 1; c.rdst = 1; end
      4'd8:  begin c.asa = 1; c.aop = 2'b11; c.pcwc = 1; c.pcs = 2'b01; end
      4'd9:  begin c.pcw = 1; c.pcs = 2'b10; end
      4'd10: begin c.asa = 1; c.asb = 2'b10; c.aop = 2'b01; end
      4'd11: c.rw = 1;
      4'd12: begin c.pcw = 1; c.pcs = 2'b11; end
      default: ;
    endcase
    if (rst) begin
      c.aop = 2'b00; c.pcw = 0; c.pcwc = 0; c.mrd = 0; c.mwr = 0; c.irw = 0; c.rw = 0; c.ill = 0;
    end
    return c;
  endfunction
  task automatic check(input string tag, input ctl_t got, input ctl_t exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic pop_check(input string tag, input logic sel);
    ctl_t e;
    @(negedge clk);
    e = sb.pop_front();
    check(tag, sel ? obs1 : obs0, e);
    @(posedge clk);
    #1;
  endtask
  // seq holds one state per nibble, first state in the low nibble
  task automatic run(input string tag, input logic [5:0] op, input logic j, input logic [31:0] seq,
                     input int n, input logic bad, input logic sel);
    opcode = op;
    jr = j;
    for (int i = 0; i < n; i++) sb.push_back(exp_ctl(seq[4*i +: 4], bad, 1'b0));
    for (int i = 0; i < n; i++) pop_check($sformatf("%s[%0d]", tag, i), sel);
  endtask
  initial begin
    @(posedge clk);
    sb.push_back(exp_ctl(4'd0, 1'b0, 1'b1));
    pop_check("reset", 1'b1);
    reset = 1'b0;
    run("lw",    6'd35, 1'b0, {4'd4, 4'd3, 4'd2, 4'd1, 4'd0}, 5, 1'b0, 1'b1);
    run("sw",    6'd43, 1'b0, {4'd5, 4'd2, 4'd1, 4'd0}, 4, 1'b0, 1'b1);
    run("rtype", 6'd0,  1'b0, {4'd7, 4'd6, 4'd1, 4'd0}, 4, 1'b0, 1'b1);
    run("jr",    6'd0,  1'b1, {4'd12, 4'd6, 4'd1, 4'd0}, 4, 1'b0, 1'b1);
    run("beq",   6'd4,  1'b0, {4'd8, 4'd1, 4'd0}, 3, 1'b0, 1'b1);
    run("j",     6'd2,  1'b0, {4'd9, 4'd1, 4'd0}, 3, 1'b0, 1'b1);
    run("addi",  6'd8,  1'b0, {4'd11, 4'd10, 4'd1, 4'd0}, 4, 1'b0, 1'b1);
    run("ill63", 6'd63, 1'b0, {4'd1, 4'd0}, 2, 1'b1, 1'b1);
    run("swpre", 6'd43, 1'b0, {4'd2, 4'd1, 4'd0}, 3, 1'b0, 1'b1);
    reset = 1'b1;
    sb.push_back(exp_ctl(4'd5, 1'b0, 1'b1));
    pop_check("rst_memwr", 1'b1);
    reset = 1'b0;
    run("post_rst", 6'd43, 1'b0, {4'd0}, 1, 1'b0, 1'b1);
    reset0 = 1'b0;
    run("addi_off", 6'd8, 1'b0, {4'd1, 4'd0}, 2, 1'b1, 1'b0);
    run("addi_off_ret", 6'd8, 1'b0, {4'd1, 4'd0}, 2, 1'b1, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
